paddle_input_writer: RTL and testbench

Writer side of the controller-to-compute DPRAM path. It synchronizes and debounces the right-paddle up/down buttons, encodes them as a paddle command, and on each game-update tick writes one command word into the DPRAM slot that the compute top reads. The block carries a sequence number and a write handshake so the compute side can detect stale or dropped updates.

---
 rtl/pingpong_pkg.sv | 37 +++
 rtl/paddle_input_writer_if.sv | 28 ++
 rtl/pingpong_debounce.sv | 52 +++++
 rtl/paddle_input_writer.sv | 113 +++++++++++
 tb/tb_paddle_input_writer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared paddle command, DPRAM word and writer FSM definitions
// Used by paddle_input_writer (producer) and the compute top (consumer) so both
// agree on the layout of the command word in the DPRAM slot.
package pingpong_pkg;

    localparam int PADDLE_SEQ_W = 6;

    // 2'b11 is deliberately unused: the writer never emits it.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } paddle_cmd_e;

    // DPRAM word layout: {cmd[1:0], seq[5:0]}
    typedef struct packed {
        paddle_cmd_e               cmd;
        logic [PADDLE_SEQ_W-1:0]   seq;
    } paddle_word_t;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_REQ  = 1'b1
    } wr_state_e;

    // Both buttons pressed cancel out to NONE.
    function automatic paddle_cmd_e encode_cmd(input logic up, input logic down);
        paddle_cmd_e c;
        case ({down, up})
            2'b01:   c = UP;
            2'b10:   c = DOWN;
            default: c = NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/paddle_input_writer_if.sv
// rtl/paddle_input_writer_if.sv - DPRAM write handshake bundle
// Signals:
//   wr_en   : write request, held until accepted (master -> slave)
//   wr_ack  : accept strobe; write happens where wr_en && wr_ack (slave -> master)
//   wr_addr : DPRAM word address (master -> slave)
//   wr_data : command word {cmd, seq} (master -> slave)
interface paddle_input_writer_if #(
    parameter int ADDR_W = 1
);
    logic              wr_en;
    logic              wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/pingpong_debounce.sv
// rtl/pingpong_debounce.sv - single-bit 2-flop synchronizer plus debouncer
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   din      : raw asynchronous input
//   dout     : debounced level; changes after CYCLES consecutive samples differ
module pingpong_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // cnt_q holds how many consecutive mismatching samples were already seen;
    // the CYCLES-th mismatch flips the level. Any agreeing sample restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign dout = level_q;

endmodule

// File: rtl/paddle_input_writer.sv
// rtl/paddle_input_writer.sv - paddle button encoder and DPRAM command writer
// Optional feature macro: PADDLE_DEBOUNCE_EN (debouncer on each button).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   btn_up_i   : raw up button (async, active-high)
//   btn_down_i : raw down button (async, active-high)
//   frame_tick : one-cycle pulse requesting one command write
//   wr         : DPRAM write handshake (master side)
//   cmd        : current debounced paddle command
//   overrun    : sticky; a tick was dropped while a write was pending
module paddle_input_writer
    import pingpong_pkg::*;
#(
    parameter int BASE_ADDRESS    = 0,
    parameter int ADDR_W          = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_up_i,
    input  logic                    btn_down_i,
    input  logic                    frame_tick,
    paddle_input_writer_if.master   wr,
    output logic [1:0]              cmd,
    output logic                    overrun
);

    localparam logic [0:0] ST_IDLE = WR_IDLE;
    localparam logic [0:0] ST_REQ  = WR_REQ;

    logic                    up_lvl;
    logic                    down_lvl;
    paddle_cmd_e             cmd_enc;
    logic [0:0]              state_q;
    logic [PADDLE_SEQ_W-1:0] seq_q;
    logic [PADDLE_SEQ_W-1:0] seq_inc;
    paddle_word_t            word_q;
    logic                    overrun_q;
    logic                    take_tick;
    logic                    drop_tick;

`ifdef PADDLE_DEBOUNCE_EN
    pingpong_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_up_i),
        .dout (up_lvl)
    );

    pingpong_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_down_i),
        .dout (down_lvl)
    );
`else
    // Debounce bypassed: plain 2-flop synchronizers feed the encoder.
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {btn_down_i, btn_up_i};
            sync2_q <= sync1_q;
        end
    end

    assign up_lvl   = sync2_q[0];
    assign down_lvl = sync2_q[1];
`endif

    assign cmd_enc = encode_cmd(up_lvl, down_lvl);
    assign seq_inc = seq_q + PADDLE_SEQ_W'(1);

    // A tick is taken when idle, or when the pending write retires on this
    // same edge (back-to-back). Otherwise, while pending, it is dropped.
    assign take_tick = frame_tick && ((state_q == ST_IDLE) || wr.wr_ack);
    assign drop_tick = frame_tick && (state_q == ST_REQ) && !wr.wr_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            seq_q     <= '0;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (take_tick) begin
                word_q.cmd <= cmd_enc;
                word_q.seq <= seq_inc;
                seq_q      <= seq_inc;
                state_q    <= ST_REQ;
            end else if (state_q == ST_REQ && wr.wr_ack) begin
                state_q    <= ST_IDLE;
            end

            if (drop_tick) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign wr.wr_en   = (state_q == ST_REQ);
    assign wr.wr_addr = ADDR_W'(BASE_ADDRESS);
    assign wr.wr_data = word_q;
    assign cmd        = cmd_enc;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_paddle_input_writer.sv
// tb/tb_paddle_input_writer.sv - directed self-checking bench for paddle_input_writer
module tb_paddle_input_writer;

    localparam int DEB = 16;
`ifdef PADDLE_DEBOUNCE_EN
    localparam int LAT    = 2 + DEB;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int LAT    = 2;
    localparam bit DEB_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up_i;
    logic       btn_down_i;
    logic       frame_tick;
    logic [1:0] cmd;
    logic       overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    paddle_input_writer_if #(.ADDR_W(1)) wr_bus ();

    paddle_input_writer #(
        .BASE_ADDRESS    (0),
        .ADDR_W          (1),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up_i   (btn_up_i),
        .btn_down_i (btn_down_i),
        .frame_tick (frame_tick),
        .wr         (wr_bus),
        .cmd        (cmd),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_cmd;

        rst           = 1'b1;
        btn_up_i      = 1'b0;
        btn_down_i    = 1'b0;
        frame_tick    = 1'b0;
        wr_bus.wr_ack = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);

        check("reset_wr_en",   32'(wr_bus.wr_en),   32'h0);
        check("reset_wr_data", 32'(wr_bus.wr_data), 32'h0);
        check("reset_cmd",     32'(cmd),            32'h0);
        check("reset_overrun", 32'(overrun),        32'h0);
        check("reset_wr_addr", 32'(wr_bus.wr_addr), 32'h0);

        // Up button latency: still NONE one cycle early, UP exactly at LAT.
        btn_up_i = 1'b1;
        step(LAT - 1);
        check("up_lat_early", 32'(cmd), 32'h0);
        step(1);
        check("up_lat_exact", 32'(cmd), 32'h1);

        btn_up_i = 1'b0;
        step(LAT + 2);
        check("up_release", 32'(cmd), 32'h0);

        // 10-cycle glitch on down: filtered with debounce, passes without.
        btn_down_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            exp_cmd = (!DEB_ON && i >= 1) ? 2'b10 : 2'b00;
            check("down_glitch", 32'(cmd), 32'(exp_cmd));
        end
        btn_down_i = 1'b0;
        step(LAT + 2);
        check("down_glitch_after", 32'(cmd), 32'h0);

        // Both held -> NONE; releasing down leaves UP.
        btn_up_i   = 1'b1;
        btn_down_i = 1'b1;
        step(LAT + 2);
        check("both_none", 32'(cmd), 32'h0);
        btn_down_i = 1'b0;
        step(LAT + 2);
        check("up_after_both", 32'(cmd), 32'h1);

        // Single acked write: wr_en for one cycle, word {UP, seq 1} = 8'h41.
        wr_bus.wr_ack = 1'b1;
        frame_tick    = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("w1_wr_en",   32'(wr_bus.wr_en),   32'h1);
        check("w1_wr_data", 32'(wr_bus.wr_data), 32'h41);
        check("w1_wr_addr", 32'(wr_bus.wr_addr), 32'h0);
        step(1);
        check("w1_wr_en_drop", 32'(wr_bus.wr_en), 32'h0);

        // Unacked write, second tick 3 cycles later is dropped.
        wr_bus.wr_ack = 1'b0;
        frame_tick    = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("w2_wr_data", 32'(wr_bus.wr_data), 32'h42);
        step(2);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("ovr_set",       32'(overrun),        32'h1);
        check("ovr_wr_en",     32'(wr_bus.wr_en),   32'h1);
        check("ovr_data_kept", 32'(wr_bus.wr_data), 32'h42);
        step(1);
        check("ovr_still_req", 32'(wr_bus.wr_en), 32'h1);
        wr_bus.wr_ack = 1'b1;
        step(1);
        check("ovr_single_write", 32'(wr_bus.wr_en), 32'h0);
        step(1);
        check("ovr_idle", 32'(wr_bus.wr_en), 32'h0);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("w3_seq_next", 32'(wr_bus.wr_data), 32'h43);
        step(1);
        check("w3_done",        32'(wr_bus.wr_en), 32'h0);
        check("ovr_sticky",     32'(overrun),      32'h1);

        // Reset with cmd NONE, then 64 back-to-back acked ticks: seq wraps.
        btn_up_i = 1'b0;
        step(LAT + 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_overrun_clear", 32'(overrun), 32'h0);
        wr_bus.wr_ack = 1'b1;
        frame_tick    = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            step(1);
            check("b2b_wr_en",   32'(wr_bus.wr_en),   32'h1);
            check("b2b_wr_data", 32'(wr_bus.wr_data), 32'(k % 64));
            check("b2b_overrun", 32'(overrun),        32'h0);
        end
        check("wrap_word_64", 32'(wr_bus.wr_data), 32'h00);
        frame_tick = 1'b0;
        step(1);
        check("b2b_end", 32'(wr_bus.wr_en), 32'h0);

        // Reset in the middle of a pending (and overrun) request.
        wr_bus.wr_ack = 1'b0;
        frame_tick    = 1'b1;
        step(1);
        check("mid_wr_en", 32'(wr_bus.wr_en), 32'h1);
        step(1);
        frame_tick = 1'b0;
        check("mid_overrun", 32'(overrun), 32'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_wr_en",   32'(wr_bus.wr_en),   32'h0);
        check("mid_rst_overrun", 32'(overrun),        32'h0);
        check("mid_rst_wr_data", 32'(wr_bus.wr_data), 32'h0);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("mid_rst_seq_restart", 32'(wr_bus.wr_data), 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
